// File: rtl/dino_game_pkg.sv
// Shared types and constants for the dino game engine and its sprite write sequencer.
package dino_game_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StJump,
        StDuck,
        StDead
    } dino_state_e;

    // Sprite display slave register map, one 8-bit coordinate per word
    localparam logic [8:0] ADDR_RUN_X  = 9'd0;
    localparam logic [8:0] ADDR_RUN_Y  = 9'd1;
    localparam logic [8:0] ADDR_JUMP_X = 9'd2;
    localparam logic [8:0] ADDR_JUMP_Y = 9'd3;
    localparam logic [8:0] ADDR_DUCK_X = 9'd4;
    localparam logic [8:0] ADDR_DUCK_Y = 9'd5;
    localparam logic [8:0] ADDR_CAC_X  = 9'd6;
    localparam logic [8:0] ADDR_CAC_Y  = 9'd7;

    localparam int unsigned NUM_REGS = 8;

    // Dino and cactus are both 32x32 boxes
    localparam logic [7:0] SPRITE_SIZE = 8'd32;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Bit offset of a register's byte inside the flattened 8x8-bit snapshot
    function automatic int unsigned reg_lsb(input logic [8:0] addr);
        return 32'(addr) * 8;
    endfunction

endpackage

// File: rtl/avmm_write_seq.sv
// Eight-beat Avalon-MM write master: snapshots eight bytes on start and pushes
// them to addresses 0..7, holding each beat while the slave asserts waitrequest.
module avmm_write_seq
    import dino_game_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [63:0] snap,
    output logic        busy,
    output logic        done,
    output logic        m_chipselect,
    output logic        m_write,
    output logic [8:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);

    logic        busy_q, busy_d;
    logic [2:0]  beat_q, beat_d;
    logic [63:0] snap_q, snap_d;
    logic        accept;

    assign accept = busy_q && !m_waitrequest;
    assign done   = accept && (beat_q == 3'(NUM_REGS - 1));
    assign busy   = busy_q;

    // Sequencer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            beat_q <= '0;
            snap_q <= '0;
        end else begin
            busy_q <= busy_d;
            beat_q <= beat_d;
            snap_q <= snap_d;
        end
    end

    // Advance on each accepted beat; a new start may overlap the final beat
    always_comb begin
        busy_d = busy_q;
        beat_d = beat_q;
        snap_d = snap_q;
        if (accept) begin
            if (done) begin
                busy_d = 1'b0;
            end else begin
                beat_d = beat_q + 3'd1;
            end
        end
        if (start && (!busy_q || done)) begin
            busy_d = 1'b1;
            beat_d = '0;
            snap_d = snap;
        end
    end

    // Bus outputs are quiet (all zero) whenever no sequence is in flight
    always_comb begin
        m_chipselect = busy_q;
        m_write      = busy_q;
        m_address    = busy_q ? {6'd0, beat_q} : 9'd0;
        m_writedata  = busy_q ? {24'd0, snap_q[{beat_q, 3'b000} +: 8]} : 32'd0;
    end

endmodule

// File: rtl/dino_game_engine.sv
// Frame-tick driven dino runner: game FSM, jump physics, cactus scroll,
// collision, and a per-frame sprite coordinate push over Avalon-MM.
module dino_game_engine
    import dino_game_pkg::*;
#(
    parameter logic [7:0]        GROUND_Y      = 8'd100,
    parameter logic [7:0]        DINO_X        = 8'd100,
    parameter logic signed [7:0] JUMP_V0       = 8'sd12,
    parameter logic signed [7:0] GRAVITY       = 8'sd1,
    parameter logic [7:0]        CAC_SPEED     = 8'd2,
    parameter logic [7:0]        CAC_RESTART_X = 8'd250,
    parameter logic [7:0]        PARK_X        = 8'd0,
    parameter logic [7:0]        PARK_Y        = 8'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        btn_jump,
    input  logic        btn_duck,
    input  logic        btn_start,
    output logic        m_chipselect,
    output logic        m_write,
    output logic [8:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        game_over,
    output logic [15:0] score
);

    dino_state_e        state_q, state_d;
    logic [7:0]         y_q, y_d;
    logic signed [7:0]  vel_q, vel_d;
    logic [7:0]         cac_x_q, cac_x_d;
    logic [15:0]        score_q, score_d;
    logic               pending_q, pending_d;

    logic               seq_busy, seq_done;
    logic               can_service, service;
    logic               moving, do_jump;
    logic signed [7:0]  vel_cur, vel_next;
    logic signed [9:0]  y_ext, vel_ext, y_next, ground_ext;
    logic [63:0]        snap;

    // A tick is taken only when the sequencer can start a new push right away
    assign can_service = !seq_busy || seq_done;
    assign service     = can_service && (frame_tick || pending_q);

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Physics, score and pending-tick registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q       <= GROUND_Y;
            vel_q     <= '0;
            cac_x_q   <= CAC_RESTART_X;
            score_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            vel_q     <= vel_d;
            cac_x_q   <= cac_x_d;
            score_q   <= score_d;
            pending_q <= pending_d;
        end
    end

    // One-deep tick queue: extra ticks while one is already waiting are lost
    always_comb begin
        pending_d = pending_q;
        if (can_service) begin
            pending_d = 1'b0;
        end else if (frame_tick) begin
            pending_d = 1'b1;
        end
    end

    // Jump arithmetic in 10-bit signed so a falling dino cannot wrap past ground
    always_comb begin
        vel_cur    = (state_q == StRun) ? JUMP_V0 : vel_q;
        vel_next   = vel_cur - GRAVITY;
        y_ext      = {2'b00, y_q};
        vel_ext    = {{2{vel_cur[7]}}, vel_cur};
        y_next     = y_ext - vel_ext;
        ground_ext = {2'b00, GROUND_Y};
    end

    // Next-state and physics update, applied only on a serviced tick
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        cac_x_d = cac_x_q;
        score_d = score_q;
        moving  = 1'b0;
        do_jump = 1'b0;
        if (service) begin
            unique case (state_q)
                StIdle: begin
                    if (btn_start) begin
                        state_d = StRun;
                        moving  = 1'b1;
                    end
                end
                StRun: begin
                    moving = 1'b1;
                    if (btn_jump) begin
                        do_jump = 1'b1;
                    end else if (btn_duck) begin
                        state_d = StDuck;
                    end
                end
                StJump: begin
                    moving  = 1'b1;
                    do_jump = 1'b1;
                end
                StDuck: begin
                    moving = 1'b1;
                    if (!btn_duck) begin
                        state_d = StRun;
                    end
                end
                StDead: begin
                    if (btn_start) begin
                        state_d = StIdle;
                        y_d     = GROUND_Y;
                        vel_d   = '0;
                        cac_x_d = CAC_RESTART_X;
                        score_d = '0;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (do_jump) begin
                if (y_next >= ground_ext) begin
                    y_d     = GROUND_Y;
                    vel_d   = '0;
                    state_d = StRun;
                end else begin
                    y_d     = y_next[7:0];
                    vel_d   = vel_next;
                    state_d = StJump;
                end
            end

            if (moving) begin
                cac_x_d = (cac_x_q < CAC_SPEED) ? CAC_RESTART_X : (cac_x_q - CAC_SPEED);
                score_d = (score_q == 16'hFFFF) ? score_q : (score_q + 16'd1);
                // Collision uses the freshly updated positions; ducking gives no cover
                if ((abs_diff(cac_x_d, DINO_X) < SPRITE_SIZE) &&
                    (abs_diff(GROUND_Y, y_d) < SPRITE_SIZE)) begin
                    state_d = StDead;
                end
            end
        end
    end

    // Outputs and the sprite snapshot for the pose the FSM is entering
    always_comb begin
        game_over = (state_q == StDead);
        score     = score_q;
        snap      = '0;
        snap[reg_lsb(ADDR_RUN_X)  +: 8] = PARK_X;
        snap[reg_lsb(ADDR_RUN_Y)  +: 8] = PARK_Y;
        snap[reg_lsb(ADDR_JUMP_X) +: 8] = PARK_X;
        snap[reg_lsb(ADDR_JUMP_Y) +: 8] = PARK_Y;
        snap[reg_lsb(ADDR_DUCK_X) +: 8] = PARK_X;
        snap[reg_lsb(ADDR_DUCK_Y) +: 8] = PARK_Y;
        snap[reg_lsb(ADDR_CAC_X)  +: 8] = cac_x_d;
        snap[reg_lsb(ADDR_CAC_Y)  +: 8] = GROUND_Y;
        unique case (state_d)
            StJump: begin
                snap[reg_lsb(ADDR_JUMP_X) +: 8] = DINO_X;
                snap[reg_lsb(ADDR_JUMP_Y) +: 8] = y_d;
            end
            StDuck: begin
                snap[reg_lsb(ADDR_DUCK_X) +: 8] = DINO_X;
                snap[reg_lsb(ADDR_DUCK_Y) +: 8] = y_d;
            end
            default: begin
                snap[reg_lsb(ADDR_RUN_X) +: 8] = DINO_X;
                snap[reg_lsb(ADDR_RUN_Y) +: 8] = y_d;
            end
        endcase
    end

    avmm_write_seq u_seq (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (service),
        .snap          (snap),
        .busy          (seq_busy),
        .done          (seq_done),
        .m_chipselect  (m_chipselect),
        .m_write       (m_write),
        .m_address     (m_address),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest)
    );

endmodule
